// File: rtl/sel_split_feeder.sv
// sel_split_feeder: buffers route tags and hands them one at a time to the select-split stage.
// Optional WAIT watchdog is compiled in with SEL_SPLIT_FEEDER_TIMEOUT_EN.
module sel_split_feeder #(
   parameter int DEPTH        = 4,
   parameter int DRIVE_CYCLES = 2,
   parameter int TIMEOUT      = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sel,
   output logic                    o_valid0,
   output logic                    o_valid1,
   output logic                    o_drive,
   input  logic                    i_free,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    err_timeout
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, SETUP, DRIVE, WAIT} stateT;
   stateT state;
   logic [DEPTH-1:0] mem;
   logic [AW-1:0] wrPtr, rdPtr;
   logic [3:0] driveCnt;
   logic selQ, freeMeta, freeSync, freeDly, freeEvt, push, pop;
   assign in_ready = count != (AW+1)'(DEPTH);
   assign push     = in_valid & in_ready;
   assign pop      = state == IDLE && count != '0;
   assign freeEvt  = freeSync & ~freeDly;
   assign busy     = state != IDLE;
   always_ff @(posedge clk)
      if (push) mem[wrPtr] <= in_sel;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         wrPtr <= wrPtr + AW'(push);
         rdPtr <= rdPtr + AW'(pop);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   // i_free is asynchronous: two flops to resynchronise, a third for edge detect
   always_ff @(posedge clk or negedge rst)
      if (!rst) {freeMeta, freeSync, freeDly} <= '0;
      else {freeMeta, freeSync, freeDly} <= {i_free, freeMeta, freeSync};
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state    <= IDLE;
         selQ     <= 1'b0;
         driveCnt <= '0;
         o_valid0 <= 1'b0;
         o_valid1 <= 1'b0;
         o_drive  <= 1'b0;
      end else
         case (state)
            IDLE:
               if (pop) begin
                  selQ     <= mem[rdPtr];
                  o_valid0 <= ~mem[rdPtr];
                  o_valid1 <= mem[rdPtr];
                  state    <= SETUP;
               end
            SETUP: begin
               o_valid0 <= ~selQ;
               o_valid1 <= selQ;
               o_drive  <= 1'b1;
               driveCnt <= '0;
               state    <= DRIVE;
            end
            DRIVE:
               if (driveCnt == 4'(DRIVE_CYCLES - 1)) begin
                  o_drive <= 1'b0;
                  state   <= WAIT;
               end else driveCnt <= driveCnt + 4'd1;
            WAIT:
               if (freeEvt) begin
                  o_valid0 <= 1'b0;
                  o_valid1 <= 1'b0;
                  state    <= IDLE;
               end
         endcase
`ifdef SEL_SPLIT_FEEDER_TIMEOUT_EN
   logic [15:0] waitCnt;
   // counter is held at zero outside WAIT, so it restarts on every WAIT entry
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         waitCnt     <= '0;
         err_timeout <= 1'b0;
      end else if (state != WAIT) waitCnt <= '0;
      else begin
         if (waitCnt != 16'(TIMEOUT)) waitCnt <= waitCnt + 16'd1;
         if (waitCnt == 16'(TIMEOUT - 1)) err_timeout <= 1'b1;
      end
`else
   assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_sel_split_feeder.sv
// tb_sel_split_feeder: directed vector table plus hand-written multi-cycle sequences.
module tb_sel_split_feeder;
   logic clk = 1'b0, rst = 1'b0, inValid = 1'b0, inSel = 1'b0, iFree = 1'b0;
   logic inReady, oValid0, oValid1, oDrive, busy, errTimeout;
   logic [2:0] count;
   int vectors = 0, miscompares = 0;

   sel_split_feeder #(.DEPTH(4), .DRIVE_CYCLES(2), .TIMEOUT(10)) dut (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_sel(inSel),
      .o_valid0(oValid0), .o_valid1(oValid1), .o_drive(oDrive), .i_free(iFree),
      .busy(busy), .count(count), .err_timeout(errTimeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic r, v, s, f;
      logic [8:0] exp;
   } vecT;

   vecT tbl[28];

   function automatic vecT mk(logic r, logic v, logic s, logic f, logic [8:0] e);
      vecT x;
      x.r = r; x.v = v; x.s = s; x.f = f; x.exp = e;
      return x;
   endfunction

   function automatic logic [8:0] obs();
      return {inReady, oValid0, oValid1, oDrive, busy, count, errTimeout};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      rst = 1'b0; inValid = 1'b0; iFree = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic freePulse();
      iFree = 1'b1;
      repeat (3) tick();
      iFree = 1'b0;
   endtask

   // advance until drive has been seen high and then low again (WAIT entry)
   task automatic waitWaitState(input string name);
      bit seen = 0, done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         tick();
         if (oDrive) seen = 1;
         if (seen && !oDrive) done = 1;
      end
      if (!done) check({name, "_timeout"}, 0, 1);
   endtask

   always @(negedge clk)
      if (rst) check("one_hot", {31'd0, oValid0 & oValid1}, 0);

   initial begin
      logic tags[5];
      int accepted;
      // exp = {in_ready, v0, v1, drive, busy, count[2:0], err}
      tbl[0]  = mk(0, 0, 0, 0, 9'b1_0_0_0_0_000_0);
      tbl[1]  = mk(1, 1, 1, 0, 9'b1_0_0_0_0_001_0);
      tbl[2]  = mk(1, 0, 0, 0, 9'b1_0_1_0_1_000_0);
      tbl[3]  = mk(1, 0, 0, 0, 9'b1_0_1_1_1_000_0);
      tbl[4]  = mk(1, 0, 0, 0, 9'b1_0_1_1_1_000_0);
      tbl[5]  = mk(1, 0, 0, 0, 9'b1_0_1_0_1_000_0);
      tbl[6]  = mk(1, 0, 0, 0, 9'b1_0_1_0_1_000_0);
      tbl[7]  = mk(1, 1, 0, 0, 9'b1_0_1_0_1_001_0);
      tbl[8]  = mk(1, 0, 0, 1, 9'b1_0_1_0_1_001_0);
      tbl[9]  = mk(1, 0, 0, 1, 9'b1_0_1_0_1_001_0);
      tbl[10] = mk(1, 0, 0, 1, 9'b1_0_0_0_0_001_0);
      tbl[11] = mk(1, 0, 0, 0, 9'b1_1_0_0_1_000_0);
      tbl[12] = mk(1, 0, 0, 0, 9'b1_1_0_1_1_000_0);
      tbl[13] = mk(1, 0, 0, 0, 9'b1_1_0_1_1_000_0);
      tbl[14] = mk(1, 0, 0, 0, 9'b1_1_0_0_1_000_0);
      for (int i = 15; i < 19; i++) tbl[i] = mk(1, 0, 0, 0, 9'b1_1_0_0_1_000_0);
      tbl[19] = mk(1, 0, 0, 1, 9'b1_1_0_0_1_000_0);
      tbl[20] = mk(1, 0, 0, 1, 9'b1_1_0_0_1_000_0);
      tbl[21] = mk(1, 0, 0, 1, 9'b1_0_0_0_0_000_0);
      tbl[22] = mk(1, 0, 0, 0, 9'b1_0_0_0_0_000_0);
      for (int i = 23; i < 26; i++) tbl[i] = mk(1, 0, 0, 1, 9'b1_0_0_0_0_000_0);
      for (int i = 26; i < 28; i++) tbl[i] = mk(1, 0, 0, 0, 9'b1_0_0_0_0_000_0);

      #1;
      for (int i = 0; i < 28; i++) begin
         rst = tbl[i].r; inValid = tbl[i].v; inSel = tbl[i].s; iFree = tbl[i].f;
         tick();
         check($sformatf("row%0d", i), {23'd0, obs()}, {23'd0, tbl[i].exp});
      end

      // FIFO full and ordered drain with tags 0,1,1,0,1
      tags = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      resetDut();
      accepted = 0;
      for (int c = 0; c < 12; c++) begin
         logic pre;
         inValid = 1'b1;
         inSel = accepted < 5 ? tags[accepted] : 1'b1;
         pre = inReady;
         tick();
         if (pre) accepted++;
      end
      inValid = 1'b0;
      check("full_accepted", accepted, 5);
      check("full_count", {29'd0, count}, 4);
      check("full_ready", {31'd0, inReady}, 0);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("order%0d", i), {30'd0, oValid1, oValid0}, tags[i] ? 2 : 1);
         freePulse();
         if (i < 4) waitWaitState("drain");
      end
      check("drain_idle", {28'd0, busy, count}, 0);

      // simultaneous push/pop at count=2, then reset mid-WAIT with count=3
      resetDut();
      inValid = 1'b1; inSel = 1'b0; tick();
      inValid = 1'b0;
      waitWaitState("pp_first");
      inValid = 1'b1; inSel = 1'b1; tick(); tick();
      inValid = 1'b0;
      check("pp_count2", {29'd0, count}, 2);
      freePulse();
      check("pp_idle", {31'd0, busy}, 0);
      inValid = 1'b1; inSel = 1'b0; tick();
      check("pp_pushpop", {28'd0, busy, count}, {28'd0, 1'b1, 3'd2});
      inSel = 1'b1; tick();
      inValid = 1'b0;
      waitWaitState("pp_wait");
      check("pp_count3", {29'd0, count}, 3);
      #3 rst = 1'b0;
      #1 check("async_reset", {23'd0, obs()}, {23'd0, 9'b1_0_0_0_0_000_0});
      tick();
      rst = 1'b1;
      freePulse();
      tick(); tick();
      check("post_reset_free", {23'd0, obs()}, {23'd0, 9'b1_0_0_0_0_000_0});

      // watchdog
      resetDut();
      inValid = 1'b1; inSel = 1'b1; tick();
      inValid = 1'b0;
      waitWaitState("to_wait");
`ifdef SEL_SPLIT_FEEDER_TIMEOUT_EN
      repeat (9) tick();
      check("timeout_before", {31'd0, errTimeout}, 0);
      tick();
      check("timeout_set", {31'd0, errTimeout}, 1);
      freePulse();
      check("timeout_sticky", {30'd0, busy, errTimeout}, 1);
`else
      repeat (20) tick();
      check("no_watchdog", {31'd0, errTimeout}, 0);
      freePulse();
      check("no_watchdog_idle", {30'd0, busy, errTimeout}, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sel_split_feeder.md
# sel_split_feeder

Clocked front end for the two-way conditional branch stage. It buffers route-tagged tokens from synchronous logic and presents them to the downstream select-split one at a time: a stable one-hot `o_valid0`/`o_valid1`, then an `o_drive` pulse. It waits for the stage's asynchronous `i_free` return before issuing the next token. It sits directly upstream of the select-split and is the clocked-to-handshake boundary for that branch.

## Interface
- `DEPTH`, 4 — token FIFO entries; power of two, ≥2.
- `DRIVE_CYCLES`, 2 — width of the `o_drive` high pulse in clk cycles; range 1..15.
- `TIMEOUT`, 255 — WAIT-state cycle limit, used only with the watchdog compiled in; range 1..65535.

- `clk`  input  1  — single clock; all state is on its rising edge.
- `rst`  input  1  — reset, asynchronous, active-low.
- `in_valid`  input  1  — upstream token present.
- `in_ready`  output  1  — FIFO not full; a token is accepted when `in_valid & in_ready`.
- `in_sel`  input  1  — route tag: 0 selects branch 0, 1 selects branch 1.
- `o_valid0`  output  1  — branch-0 select level to the split stage.
- `o_valid1`  output  1  — branch-1 select level to the split stage.
- `o_drive`  output  1  — drive request to the split stage.
- `i_free`  input  1  — free return from the split stage; asynchronous to clk.
- `busy`  output  1  — FSM is not in IDLE.
- `count`  output  $clog2(DEPTH)+1  — FIFO occupancy, 0..DEPTH.
- `err_timeout`  output  1  — sticky watchdog flag.

## Operation
- **FIFO.** The FIFO holds `in_sel` tags.
  - Push and pop can occur in the same cycle; `count` is then unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - `in_ready = (count != DEPTH)`. A push attempted while full is ignored.
- **`i_free` path.** `i_free` passes through a 2-flop synchronizer, then a rising-edge detect, producing `free_evt`.
  - Integration guarantees each `i_free` high pulse is ≥2 clk periods and that pulses are spaced ≥3 clk periods apart.
- **FSM states: IDLE, SETUP, DRIVE, WAIT.**
  - IDLE: if `count != 0`, pop the head tag into `sel_q` and go to SETUP. Otherwise stay in IDLE.
  - SETUP: `o_valid[sel_q]` is high and `o_drive` is low. Lasts one cycle, then go to DRIVE. This guarantees valid is stable before drive.
  - DRIVE: `o_drive` is high and the valid level is held. After DRIVE_CYCLES cycles, go to WAIT.
  - WAIT: the valid level is held and `o_drive` is low. On `free_evt`, go to IDLE; both valids drop in that cycle.
- **`free_evt` outside WAIT.** It is ignored; no state change and no error.
- **One-hot rule.** `o_valid0 & o_valid1` is never 1. Both valids are 0 in IDLE.
- **Registered outputs.** `o_valid0`, `o_valid1` and `o_drive` are registered; no combinational path from any input reaches them.
- **Reset mid-operation.** Asserting `rst` at any time does all of the following:
  - forces IDLE;
  - empties the FIFO;
  - clears the synchronizer, `sel_q`, the drive counter and `err_timeout`.
  A token in flight downstream is abandoned; the split stage is reset by the same `rst` net.

## Timing
- **Reset values.** `in_ready=1`, `o_valid0=0`, `o_valid1=0`, `o_drive=0`, `busy=0`, `count=0`, `err_timeout=0`.
- **Accept to drive, idle block.** A push at edge k gives:
  - `count=1` after edge k;
  - pop and SETUP entry at edge k+1, with valid high after k+1;
  - `o_drive` high after edge k+2, for DRIVE_CYCLES cycles.
- **Free to IDLE.** `i_free` rising before edge m gives `free_evt` at edge m+2 and IDLE entry at that edge.
- **Back-to-back tokens.** IDLE always lasts ≥1 cycle. With the FIFO non-empty, the minimum token period is 3 + DRIVE_CYCLES + handshake latency.

## Configuration
- **Macro:** `SEL_SPLIT_FEEDER_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT, `err_timeout` sets and stays set until `rst`.
  - The FSM remains in WAIT; a later `free_evt` still returns it to IDLE.
- **Undefined:** no counter is built, `err_timeout` is tied to 0, and the TIMEOUT parameter is unused.

## Test plan
- **Reset:** release `rst`; push tag 1 with no `i_free` → `o_valid1` high 1 cycle before `o_drive`; `o_drive` high exactly 2 cycles; `o_valid1` held; `busy=1`.
- **Full handshake:** tag 0 with `i_free` pulsed 3 cycles wide, 5 cycles after drive falls → `o_valid0` drops 2–3 cycles after the `i_free` rise; FSM returns to IDLE.
- **FIFO full:** hold `in_valid` with no free returns and DEPTH=4 → 5 tokens accepted (1 in flight, 4 buffered); `in_ready=0`; `count=4`; the 6th push is ignored.
- **Simultaneous push and pop:** push while IDLE pops with `count=2` → `count` stays 2; order preserved for the tag sequence 0,1,1,0,1.
- **Reset mid-WAIT:** pulse `rst` with `count=3` → all outputs at reset values asynchronously; a subsequent `i_free` is ignored.
- **Timeout (macro defined, TIMEOUT=10):** no `i_free` → `err_timeout=1` after the 10th WAIT cycle; a later `free_evt` returns the FSM to IDLE while `err_timeout` stays 1. With the macro undefined, `err_timeout` stays 0.
